// File: rtl/legup_div_sequential.sv
// Iterative radix-2 restoring divider, one quotient bit per enabled cycle.
// A start/done handshake replaces a fixed pipeline depth. clken stalls the
// whole unit, matching the multiplier units.
//
// Ports:
//   clock        rising-edge clock
//   resetn       synchronous active-low reset (has priority over clken)
//   clken        clock enable; low freezes all state and outputs
//   start        request, accepted only in IDLE
//   dataa        dividend (widtha bits), captured on accepted start
//   datab        divisor (widthb bits), captured on accepted start
//   busy         high from the cycle after acceptance until done
//   done         one-cycle pulse (stretched while clken is low)
//   div_by_zero  valid with done; captured divisor was zero
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//
// state | meaning
// IDLE  | waiting for start; result outputs hold
// PREP  | form operand magnitudes and result signs, load the iterator
// ITER  | widtha shift/subtract steps; the last step registers the results
// FIX   | done visible, busy low; start here is ignored
module legup_div_sequential #(
  parameter int    widtha         = 32,
  parameter int    widthb         = 32,
  parameter string representation = "UNSIGNED"
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clken,
  input  logic              start,
  input  logic [widtha-1:0] dataa,
  input  logic [widthb-1:0] datab,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [widtha-1:0] quotient,
  output logic [widthb-1:0] remainder
);

  localparam bit is_signed = (representation == "SIGNED");
  localparam int CW = $clog2(widtha + 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]     count;
  logic [widtha-1:0] a_reg;
  logic [widthb-1:0] b_reg;
  logic [widtha-1:0] q_sr;
  logic [widthb-1:0] rem;
  logic [widthb-1:0] b_mag;
  logic              rem_neg;
  logic              q_neg;

  logic              accept;
  logic              last_iter;
  logic              a_sign;
  logic              b_sign;
  logic [widthb:0]   shifted;
  logic              trial_ok;
  logic [widthb-1:0] rem_step;
  logic [widtha-1:0] q_step;
  logic              div0;
  logic [widtha-1:0] q_final;
  logic [widthb-1:0] r_final;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = PREP;
        end
      end
      PREP: state_next = ITER;
      ITER: begin
        if (count == CW'(1)) begin
          last_iter  = 1'b1;
          state_next = FIX;
        end
      end
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn)
      state <= IDLE;
    else if (clken)
      state <= state_next;
  end

  // One restoring step. The shifted partial remainder is below 2*|b|, so
  // when it is at least |b| the widthb-bit difference is exact; when it is
  // smaller its top bit is zero and the low bits are the restored value.
  always_comb begin
    a_sign   = is_signed && a_reg[widtha-1];
    b_sign   = is_signed && b_reg[widthb-1];
    shifted  = {rem, q_sr[widtha-1]};
    trial_ok = (shifted >= {1'b0, b_mag});
    if (trial_ok) begin
      rem_step = shifted[widthb-1:0] - b_mag;
      q_step   = {q_sr[widtha-2:0], 1'b1};
    end else begin
      rem_step = shifted[widthb-1:0];
      q_step   = {q_sr[widtha-2:0], 1'b0};
    end
    div0 = (b_reg == '0);
    // Divide by zero reports the raw dividend bits, bypassing sign fix-up.
    if (div0) begin
      q_final = '1;
      r_final = a_reg[widthb-1:0];
    end else begin
      q_final = q_neg ? -q_step : q_step;
      r_final = rem_neg ? -rem_step : rem_step;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      q_sr        <= '0;
      rem         <= '0;
      b_mag       <= '0;
      rem_neg     <= 1'b0;
      q_neg       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else if (clken) begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= dataa;
            b_reg <= datab;
            busy  <= 1'b1;
          end
        end
        PREP: begin
          rem_neg <= a_sign;
          q_neg   <= a_sign ^ b_sign;
          q_sr    <= a_sign ? -a_reg : a_reg;
          b_mag   <= b_sign ? -b_reg : b_reg;
          rem     <= '0;
          count   <= CW'(widtha);
        end
        ITER: begin
          rem   <= rem_step;
          q_sr  <= q_step;
          count <= count - CW'(1);
          // Results are registered on entry to FIX so done and the values
          // are visible together during the FIX cycle.
          if (last_iter) begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= div0;
            done        <= 1'b1;
            busy        <= 1'b0;
          end
        end
        FIX: done <= 1'b0;
        default: done <= 1'b0;
      endcase
    end
  end

endmodule
